fetch_unit: RTL and testbench

- Instruction-fetch stage of the 16-bit CPU.
- Owns the program counter and drives the 8-bit address into the combinational instruction memory.
- Registers the returned 16-bit word into the instruction register (IR) for decode.
- Handles start/halt sequencing, decode stalls and taken-branch redirects, inserting a bubble on redirect.

---
 rtl/fetch_unit.sv | 138 +++++++++++++
 tb/tb_fetch_unit.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: program counter, instruction register and IDLE/RUN/HALT sequencing for the 16-bit CPU.
// Optional macro FETCH_PERF_EN adds a saturating fetch_count output.
`ifndef HALT
`define HALT 5'b11111
`endif

module fetch_unit #(
   parameter int                    ADDR_WIDTH  = 8,
   parameter int                    INSTR_WIDTH = 16,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
   parameter logic [4:0]            HALT_OPCODE = `HALT
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   enable,
   input  logic                   start,
   output logic [ADDR_WIDTH-1:0]  i_addr,
   input  logic [INSTR_WIDTH-1:0] i_datain,
   input  logic                   stall,
   input  logic                   branch_taken,
   input  logic [ADDR_WIDTH-1:0]  branch_addr,
   output logic [INSTR_WIDTH-1:0] ir,
   output logic [ADDR_WIDTH-1:0]  ir_pc,
   output logic                   ir_valid,
   output logic                   running,
   output logic                   halted
`ifdef FETCH_PERF_EN
   ,
   output logic [15:0]            fetch_count
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] PC_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

   state_t                  state_r;
   logic [ADDR_WIDTH-1:0]   pc_r;
   logic                    halt_word_s;

   assign i_addr      = pc_r;
   assign halt_word_s = (i_datain[INSTR_WIDTH-1 -: 5] == HALT_OPCODE);

   // Sequencer: state, PC and the registered IR / status outputs.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r  <= ST_IDLE;
         pc_r     <= RESET_PC;
         ir       <= '0;
         ir_pc    <= '0;
         ir_valid <= 1'b0;
         running  <= 1'b0;
         halted   <= 1'b0;
      end else if (enable) begin
         case (state_r)
            ST_IDLE: begin
               pc_r     <= RESET_PC;
               ir_valid <= 1'b0;
               if (start) begin
                  state_r <= ST_RUN;
                  running <= 1'b1;
                  halted  <= 1'b0;
               end
            end
            ST_RUN: begin
               // Redirect beats stall; the word on i_datain is dropped, leaving one bubble.
               if (branch_taken) begin
                  pc_r     <= branch_addr;
                  ir       <= '0;
                  ir_valid <= 1'b0;
               end else if (stall) begin
                  pc_r     <= pc_r;
               end else if (halt_word_s) begin
                  ir       <= i_datain;
                  ir_pc    <= pc_r;
                  ir_valid <= 1'b1;
                  state_r  <= ST_HALT;
                  running  <= 1'b0;
                  halted   <= 1'b1;
               end else begin
                  ir       <= i_datain;
                  ir_pc    <= pc_r;
                  ir_valid <= 1'b1;
                  pc_r     <= pc_r + PC_ONE;
               end
            end
            ST_HALT: begin
               if (start) begin
                  state_r  <= ST_RUN;
                  pc_r     <= RESET_PC;
                  ir_valid <= 1'b0;
                  running  <= 1'b1;
                  halted   <= 1'b0;
               end
            end
            default: begin
               state_r  <= ST_IDLE;
               pc_r     <= RESET_PC;
               ir_valid <= 1'b0;
               running  <= 1'b0;
               halted   <= 1'b0;
            end
         endcase
      end
   end

`ifdef FETCH_PERF_EN
   logic [15:0] count_r;
   logic        fetch_fire_s;
   logic        count_clr_s;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   assign fetch_fire_s = enable && (state_r == ST_RUN) && !branch_taken && !stall;
   assign count_clr_s  = enable && start && (state_r != ST_RUN);
   assign fetch_count  = count_r;

   // Counts real fetches (including the HALT fetch); cleared on reset and on start.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count_r <= 16'h0000;
      end else if (count_clr_s) begin
         count_r <= 16'h0000;
      end else if (fetch_fire_s) begin
         count_r <= sat_inc(count_r);
      end else begin
         count_r <= count_r;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed test-plan sequences plus randomized traffic,
// checked against a behavioural model of the fetch stage.
`ifndef HALT
`define HALT 5'b11111
`endif

module tb_fetch_unit;
   localparam logic [4:0] HALT_OP = `HALT;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b0, start = 1'b0, stall = 1'b0, branch_taken = 1'b0;
   logic [7:0]  branch_addr = 8'h00;
   logic [7:0]  i_addr;
   logic [15:0] i_datain;
   logic [15:0] ir;
   logic [7:0]  ir_pc;
   logic        ir_valid, running, halted;
`ifdef FETCH_PERF_EN
   logic [15:0] fetch_count;
`endif

   fetch_unit dut (
      .clock(clock), .reset(reset), .enable(enable), .start(start),
      .i_addr(i_addr), .i_datain(i_datain), .stall(stall),
      .branch_taken(branch_taken), .branch_addr(branch_addr),
      .ir(ir), .ir_pc(ir_pc), .ir_valid(ir_valid),
      .running(running), .halted(halted)
`ifdef FETCH_PERF_EN
      , .fetch_count(fetch_count)
`endif
   );

   always #5 clock = ~clock;

   logic [15:0] mem [256];
   always_comb i_datain = mem[i_addr];

   typedef struct {
      logic [7:0]  pc;
      logic [15:0] ir;
      logic [7:0]  irpc;
      logic        v, r, h;
      logic [15:0] cnt;
   } exp_t;
   exp_t sb[$];

   int checks = 0, passes = 0;

   // Reference model of the fetch stage as plain variables.
   logic [7:0]  m_pc = 8'h00;
   logic [15:0] m_ir = 16'h0000;
   logic [7:0]  m_irpc = 8'h00;
   logic        m_valid = 1'b0, m_run = 1'b0, m_halt = 1'b0;
   logic [15:0] m_cnt = 16'h0000;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   task automatic model_reset();
      m_pc = 8'h00; m_ir = 16'h0000; m_irpc = 8'h00;
      m_valid = 1'b0; m_run = 1'b0; m_halt = 1'b0; m_cnt = 16'h0000;
   endtask

   task automatic model_step(input bit en, input bit st, input bit stl, input bit br,
                             input logic [7:0] ba);
      if (!en) return;
      if (!m_run) begin
         if (st) begin
            m_run = 1'b1; m_halt = 1'b0; m_pc = 8'h00; m_valid = 1'b0; m_cnt = 16'h0000;
         end
      end else if (br) begin
         m_pc = ba; m_ir = 16'h0000; m_valid = 1'b0;
      end else if (!stl) begin
         m_ir = mem[m_pc]; m_irpc = m_pc; m_valid = 1'b1;
         if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
         if (m_ir[15:11] == HALT_OP) begin
            m_run = 1'b0; m_halt = 1'b1;
         end else begin
            m_pc = m_pc + 8'd1;
         end
      end
   endtask

   task automatic cyc(input bit en, input bit st, input bit stl, input bit br,
                      input logic [7:0] ba);
      @(posedge clock); #2;
      enable = en; start = st; stall = stl; branch_taken = br; branch_addr = ba;
      model_step(en, st, stl, br, ba);
      sb.push_back('{m_pc, m_ir, m_irpc, m_valid, m_run, m_halt, m_cnt});
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_i_addr"}, {24'h0, i_addr}, 32'h0);
      check({tag, "_ir"}, {16'h0, ir}, 32'h0);
      check({tag, "_ir_pc"}, {24'h0, ir_pc}, 32'h0);
      check({tag, "_ir_valid"}, {31'h0, ir_valid}, 32'h0);
      check({tag, "_running"}, {31'h0, running}, 32'h0);
      check({tag, "_halted"}, {31'h0, halted}, 32'h0);
`ifdef FETCH_PERF_EN
      check({tag, "_fetch_count"}, {16'h0, fetch_count}, 32'h0);
`endif
   endtask

   // Monitor: one expected snapshot per clock edge, sampled just after the edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clock); #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("i_addr", {24'h0, i_addr}, {24'h0, e.pc});
            check("ir", {16'h0, ir}, {16'h0, e.ir});
            check("ir_pc", {24'h0, ir_pc}, {24'h0, e.irpc});
            check("ir_valid", {31'h0, ir_valid}, {31'h0, e.v});
            check("running", {31'h0, running}, {31'h0, e.r});
            check("halted", {31'h0, halted}, {31'h0, e.h});
`ifdef FETCH_PERF_EN
            check("fetch_count", {16'h0, fetch_count}, {16'h0, e.cnt});
`endif
         end
      end
   end

   task automatic run_until_pc(input logic [7:0] target, input string tag);
      int n = 0;
      while (m_pc != target && n < 100) begin
         cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
         n++;
      end
      check({tag, "_reached"}, {24'h0, m_pc}, {24'h0, target});
   endtask

   initial begin
      for (int a = 0; a < 256; a++) begin
         logic [15:0] w;
         w = 16'($urandom);
         if (w[15:11] == HALT_OP) w[11] = ~w[11];
         mem[a] = w;
      end
      mem[16]    = {HALT_OP, 11'h155};
      mem[8'h40] = {HALT_OP, 11'h0A3};
      mem[8'hA0] = {HALT_OP, 11'h7FF};

      // Power-on reset
      repeat (3) @(posedge clock);
      #2;
      check_reset_outputs("por");
      reset = 1'b0;
      model_reset();

      // Sequential fetch, stall at pc 5, branch at pc 7 to 0x0B, HALT at 16
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
      run_until_pc(8'd5, "to5");
      repeat (3) cyc(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
      run_until_pc(8'd7, "to7");
      cyc(1'b1, 1'b0, 1'b0, 1'b1, 8'h0B);
      begin
         int n = 0;
         while (!m_halt && n < 100) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
            n++;
         end
         check("halt_reached", {31'h0, m_halt}, 32'h1);
      end
      repeat (5) cyc(1'b1, 1'b0, 1'($urandom), 1'($urandom), 8'($urandom));

      // Restart, then wrap the PC through 8'hFF
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
      cyc(1'b1, 1'b0, 1'b0, 1'b1, 8'hFD);
      repeat (6) cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      cyc(1'b1, 1'b0, 1'b0, 1'b1, 8'h0B);
      cyc(1'b1, 1'b0, 1'b0, 1'b1, 8'h30);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         cyc(($urandom % 10) != 0, ($urandom % 25) == 0, ($urandom % 5) == 0,
             ($urandom % 8) == 0, 8'($urandom));
      end

      // Reset in the middle of RUN with stall and branch_taken high
      begin
         int n = 0;
         while (!m_run && n < 10) begin
            cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
            n++;
         end
      end
      repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      check("pre_reset_running", {31'h0, running}, 32'h1);
      @(posedge clock); #2;
      enable = 1'b1; stall = 1'b1; branch_taken = 1'b1; branch_addr = 8'h55; reset = 1'b1;
      #1;
      check_reset_outputs("midrun");
      model_reset();
      @(posedge clock); #2;
      check_reset_outputs("held");
      reset = 1'b0; enable = 1'b0; stall = 1'b0; branch_taken = 1'b0;
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
      repeat (4) cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);

      repeat (3) @(posedge clock);
      #3;
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
